e_mdu: RTL and testbench

Parametrised multiply/divide unit for the E stage of the 5-stage pipeline. It owns the HI/LO registers and executes mult/div, multiply-accumulate and mthi/mtlo with configurable multi-cycle latency. It exports a busy/stall signal so the hazard unit can hold md instructions in D, and it supports a flush that aborts an in-flight operation. mfhi/mflo read E_HI/E_LO combinationally.

---
 rtl/md_pkg.sv | 33 +++
 rtl/e_mdu_if.sv | 26 ++
 rtl/md_calc.sv | 68 ++++++
 rtl/e_mdu.sv | 87 ++++++++
 tb/tb_e_mdu.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Operation codes and helpers shared by the E-stage multiply/divide unit.
package md_pkg;

    localparam int MD_OP_W = 4;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_e;

    // Ops that occupy the unit for several cycles; codes 11-15 fall through as no-ops.
    function automatic logic is_md_long(input logic [MD_OP_W-1:0] op);
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

    function automatic logic is_md_div(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu_if.sv
// Request/status bundle between the E stage (master) and the multiply/divide unit (slave).
interface e_mdu_if
    import md_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic               E_MDStart;
    logic [MD_OP_W-1:0] E_MDOp;
    logic [DATA_W-1:0]  E_MDA;
    logic [DATA_W-1:0]  E_MDB;
    logic               E_MDFlush;
    logic               E_MDBusy;
    logic               E_MDStall;
    logic [DATA_W-1:0]  E_HI;
    logic [DATA_W-1:0]  E_LO;

    modport master (
        output E_MDStart, E_MDOp, E_MDA, E_MDB, E_MDFlush,
        input  E_MDBusy, E_MDStall, E_HI, E_LO
    );

    modport slave (
        input  E_MDStart, E_MDOp, E_MDA, E_MDB, E_MDFlush,
        output E_MDBusy, E_MDStall, E_HI, E_LO
    );
endinterface

// File: rtl/md_calc.sv
// Combinational result path: next {HI,LO} for a latched multi-cycle op.
module md_calc
    import md_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [MD_OP_W-1:0] op,
    input  logic [DATA_W-1:0]  a,
    input  logic [DATA_W-1:0]  b,
    input  logic [DATA_W-1:0]  hi,
    input  logic [DATA_W-1:0]  lo,
    output logic [DATA_W-1:0]  hi_nxt,
    output logic [DATA_W-1:0]  lo_nxt
);
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic [2*DATA_W-1:0]        acc;
    logic signed [2*DATA_W-1:0] prod_s;
    logic [2*DATA_W-1:0]        prod_u;
    logic signed [DATA_W-1:0]   quo_s;
    logic signed [DATA_W-1:0]   rem_s;
    logic [DATA_W-1:0]          quo_u;
    logic [DATA_W-1:0]          rem_u;
    logic [2*DATA_W-1:0]        res;

    assign acc = {hi, lo};

    // Full-width operands so the truncated product is exact modulo 2^(2*DATA_W).
    assign prod_s = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
    assign prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

    assign quo_s = $signed(a) / $signed(b);
    assign rem_s = $signed(a) % $signed(b);
    assign quo_u = a / b;
    assign rem_u = a % b;

    always_comb begin
        // NOTE: default first so every path assigns res and no latch is inferred.
        res = acc;
        case (op)
            MD_MULT:  res = prod_s;
            MD_MULTU: res = prod_u;
            MD_MADD:  res = acc + prod_s;
            MD_MADDU: res = acc + prod_u;
            MD_MSUB:  res = acc - prod_s;
            MD_MSUBU: res = acc - prod_u;
            MD_DIV: begin
                if (b == '0)
                    res = {a, {DATA_W{1'b1}}};
                else if (a == MIN_NEG && b == {DATA_W{1'b1}})
                    res = {{DATA_W{1'b0}}, a};
                else
                    res = {rem_s, quo_s};
            end
            MD_DIVU: begin
                if (b == '0)
                    res = {a, {DATA_W{1'b1}}};
                else
                    res = {rem_u, quo_u};
            end
            default: res = acc;
        endcase
    end

    assign hi_nxt = res[2*DATA_W-1:DATA_W];
    assign lo_nxt = res[DATA_W-1:0];

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs multi-cycle ops, reports busy/stall.
module e_mdu
    import md_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic    clk,
    input  logic    reset,
    e_mdu_if.slave  md
);
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [MD_OP_W-1:0] op_q;
    logic [DATA_W-1:0]  a_q, b_q;
    logic [DATA_W-1:0]  hi_q, lo_q;
    logic [DATA_W-1:0]  hi_nxt, lo_nxt;
    logic [DATA_W-1:0]  calc_hi, calc_lo;
    logic               busy;
    logic               load;

    assign busy = (cnt != '0);

    md_calc #(.DATA_W(DATA_W)) u_calc (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .hi     (hi_q),
        .lo     (lo_q),
        .hi_nxt (calc_hi),
        .lo_nxt (calc_lo)
    );

    // Flush beats completion and accept; starts while busy are dropped.
    always_comb begin
        cnt_nxt = cnt;
        hi_nxt  = hi_q;
        lo_nxt  = lo_q;
        load    = 1'b0;
        if (md.E_MDFlush) begin
            cnt_nxt = '0;
        end else if (busy) begin
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                hi_nxt = calc_hi;
                lo_nxt = calc_lo;
            end
        end else if (md.E_MDStart) begin
            if (is_md_long(md.E_MDOp)) begin
                load    = 1'b1;
                cnt_nxt = is_md_div(md.E_MDOp) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
            end else if (md.E_MDOp == MD_MTHI) begin
                hi_nxt = md.E_MDA;
            end else if (md.E_MDOp == MD_MTLO) begin
                lo_nxt = md.E_MDA;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            cnt  <= cnt_nxt;
            hi_q <= hi_nxt;
            lo_q <= lo_nxt;
            if (load) begin
                op_q <= md.E_MDOp;
                a_q  <= md.E_MDA;
                b_q  <= md.E_MDB;
            end
        end
    end

    assign md.E_MDBusy  = busy;
    assign md.E_MDStall = md.E_MDStart | busy;
    assign md.E_HI      = hi_q;
    assign md.E_LO      = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Randomized self-checking bench for e_mdu against a transaction-level HI/LO model.
module tb_e_mdu;
    import md_pkg::*;

    localparam int DW = 32;
    localparam int ML = 5;
    localparam int DL = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    e_mdu_if #(.DATA_W(DW)) bus ();

    e_mdu #(.DATA_W(DW), .MULT_LAT(ML), .DIV_LAT(DL), .CNT_W(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] m_hi, m_lo;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag, input logic busy);
        check({tag, ".busy"}, 64'(bus.E_MDBusy), 64'(busy));
        check({tag, ".hi"},   64'(bus.E_HI),     64'(m_hi));
        check({tag, ".lo"},   64'(bus.E_LO),     64'(m_lo));
    endtask

    // Reference result straight from the arithmetic rules, using 64-bit integers.
    function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] acc);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, qu, ru;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            4'd1:  return sa * sb;
            4'd2:  return ua * ub;
            4'd7:  return acc + (sa * sb);
            4'd8:  return acc + (ua * ub);
            4'd9:  return acc - (sa * sb);
            4'd10: return acc - (ua * ub);
            4'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                qu = ua / ub;
                ru = ua % ub;
                return {ru[31:0], qu[31:0]};
            end
            default: return acc;
        endcase
    endfunction

    // Issue one op; optionally flush or fire a stray start in busy cycle N (0 = never).
    task automatic exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input int poke_at);
        logic [63:0] res;
        bit          is_long;
        int          lat;
        is_long = op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10};
        lat     = (op == 4'd3 || op == 4'd4) ? DL : ML;
        bus.E_MDStart = 1'b1;
        bus.E_MDOp    = op;
        bus.E_MDA     = a;
        bus.E_MDB     = b;
        #1;
        check("stall_accept", 64'(bus.E_MDStall), 64'd1);
        tick();
        bus.E_MDStart = 1'b0;
        if (!is_long) begin
            if (op == 4'd5) m_hi = a;
            else if (op == 4'd6) m_lo = a;
            #1;
            check_regs("short", 1'b0);
            return;
        end
        res = ref_md(op, a, b, {m_hi, m_lo});
        for (int i = 1; i <= lat; i++) begin
            if (i == poke_at) begin
                bus.E_MDStart = 1'b1;
                bus.E_MDOp    = 4'd1;
                bus.E_MDA     = $urandom;
                bus.E_MDB     = $urandom;
            end
            if (i == flush_at) bus.E_MDFlush = 1'b1;
            #1;
            check_regs("busy", 1'b1);
            check("stall_busy", 64'(bus.E_MDStall), 64'd1);
            tick();
            bus.E_MDStart = 1'b0;
            bus.E_MDFlush = 1'b0;
            if (i == flush_at) begin
                #1;
                check_regs("flushed", 1'b0);
                return;
            end
        end
        {m_hi, m_lo} = res;
        #1;
        check_regs("done", 1'b0);
        check("stall_idle", 64'(bus.E_MDStall), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0] r_op;
        int         fa, pa;
        reset         = 1'b1;
        bus.E_MDStart = 1'b0;
        bus.E_MDOp    = '0;
        bus.E_MDA     = '0;
        bus.E_MDB     = '0;
        bus.E_MDFlush = 1'b0;
        m_hi = '0;
        m_lo = '0;
        tick();
        tick();
        check_regs("reset", 1'b0);
        reset = 1'b0;
        tick();
        check_regs("post_reset", 1'b0);

        // Reset mid-operation clears HI/LO and busy without waiting for a clock
        exec(4'd5, 32'h55, 32'h0, 0, 0);
        exec(4'd6, 32'hAA, 32'h0, 0, 0);
        bus.E_MDStart = 1'b1;
        bus.E_MDOp    = 4'd1;
        bus.E_MDA     = 32'd9;
        bus.E_MDB     = 32'd9;
        tick();
        bus.E_MDStart = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        m_hi = '0;
        m_lo = '0;
        check_regs("reset_midop", 1'b0);
        tick();
        reset = 1'b0;
        tick();

        exec(4'd1, 32'hFFFF_FFFE, 32'd3, 0, 0);
        check("mult_hi", 64'(bus.E_HI), 64'hFFFF_FFFF);
        check("mult_lo", 64'(bus.E_LO), 64'hFFFF_FFFA);
        exec(4'd2, 32'hFFFF_FFFE, 32'd3, 0, 0);
        check("multu_hi", 64'(bus.E_HI), 64'h2);
        check("multu_lo", 64'(bus.E_LO), 64'hFFFF_FFFA);
        exec(4'd8, 32'd1, 32'd6, 0, 0);
        check("maddu_hi", 64'(bus.E_HI), 64'h3);
        check("maddu_lo", 64'(bus.E_LO), 64'h0);
        exec(4'd3, 32'hFFFF_FFF9, 32'd2, 0, 0);
        check("div_hi", 64'(bus.E_HI), 64'hFFFF_FFFF);
        check("div_lo", 64'(bus.E_LO), 64'hFFFF_FFFD);
        exec(4'd4, 32'd7, 32'd0, 0, 0);
        check("divu0_hi", 64'(bus.E_HI), 64'h7);
        check("divu0_lo", 64'(bus.E_LO), 64'hFFFF_FFFF);
        exec(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check("divovf_hi", 64'(bus.E_HI), 64'h0);
        check("divovf_lo", 64'(bus.E_LO), 64'h8000_0000);
        exec(4'd5, 32'h1234, 32'h0, 0, 0);
        check("mthi_hi", 64'(bus.E_HI), 64'h1234);

        // Stray MULT while a DIV runs must not disturb the DIV result
        exec(4'd3, 32'd100, 32'd7, 0, 2);
        check("div_poke_lo", 64'(bus.E_LO), 64'd14);
        check("div_poke_hi", 64'(bus.E_HI), 64'd2);
        // Flush in busy cycle 3 together with a MULT start
        exec(4'd3, 32'd50, 32'd3, 3, 3);

        // Flush while idle blocks an MTHI accept
        bus.E_MDStart = 1'b1;
        bus.E_MDOp    = 4'd5;
        bus.E_MDA     = 32'hDEAD_BEEF;
        bus.E_MDFlush = 1'b1;
        tick();
        bus.E_MDStart = 1'b0;
        bus.E_MDFlush = 1'b0;
        #1;
        check_regs("idle_flush", 1'b0);

        for (int k = 0; k < 300; k++) begin
            r_op = 4'($urandom_range(0, 15));
            fa   = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, DL)) : 0;
            pa   = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, DL)) : 0;
            exec(r_op, pick(), pick(), fa, pa);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
